// File: rtl/mannix_mem_pkg.sv
// ---------------------------------------------------------------------------
// mannix_mem_pkg
// Shared constants and types for the Mannix SRAM read arbiter.
//   NUM_CLIENTS / ADDR_W / LEN_W : default sizing of the arbiter
//   ID_W                         : width of client index fields (prio_id, mem_id)
//   client_e                     : fixed client index assignment
//   state_e                      : arbiter FSM states
// ---------------------------------------------------------------------------
package mannix_mem_pkg;

  localparam int NUM_CLIENTS = 6;
  localparam int ADDR_W      = 19;
  localparam int LEN_W       = 4;
  localparam int ID_W        = 3;

  typedef enum logic [ID_W-1:0] {
    FCC_PIC  = 3'd0,
    FCC_WGT  = 3'd1,
    FCC_BIAS = 3'd2,
    CNN_PIC  = 3'd3,
    CNN_WGT  = 3'd4,
    POOL     = 3'd5
  } client_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/mannix_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mannix_mem_arbiter_if
// Bundle of client request signals and SRAM read-port signals.
//   Client side : req, req_addr, req_len, prio_en, prio_id -> arbiter
//                 gnt, done, busy                           <- arbiter
//   SRAM side   : mem_ready                                 -> arbiter
//                 mem_rd, mem_addr, mem_last, mem_id        <- arbiter
// Modports:
//   master : the arbiter (masters the SRAM read port)
//   slave  : the environment (clients + SRAM)
// ---------------------------------------------------------------------------
interface mannix_mem_arbiter_if #(
  parameter int NUM_CLIENTS = mannix_mem_pkg::NUM_CLIENTS,
  parameter int ADDR_W      = mannix_mem_pkg::ADDR_W,
  parameter int LEN_W       = mannix_mem_pkg::LEN_W
);

  logic [NUM_CLIENTS-1:0]             req;
  logic [NUM_CLIENTS-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_CLIENTS-1:0][LEN_W-1:0]  req_len;
  logic                               prio_en;
  logic [2:0]                         prio_id;
  logic                               mem_ready;

  logic [NUM_CLIENTS-1:0]             gnt;
  logic                               mem_rd;
  logic [ADDR_W-1:0]                  mem_addr;
  logic                               mem_last;
  logic [2:0]                         mem_id;
  logic [NUM_CLIENTS-1:0]             done;
  logic                               busy;

  modport master (
    input  req, req_addr, req_len, prio_en, prio_id, mem_ready,
    output gnt, mem_rd, mem_addr, mem_last, mem_id, done, busy
  );

  modport slave (
    output req, req_addr, req_len, prio_en, prio_id, mem_ready,
    input  gnt, mem_rd, mem_addr, mem_last, mem_id, done, busy
  );

endinterface

// File: rtl/mannix_rr_pick.sv
// ---------------------------------------------------------------------------
// mannix_rr_pick
// Combinational rotating-priority pick: first requesting client at or after
// ptr, wrapping at NUM_CLIENTS.
//   req    : per-client request vector
//   ptr    : round-robin start index (expected < NUM_CLIENTS)
//   winner : index of the selected client (0 when valid=0)
//   valid  : at least one request present
// ---------------------------------------------------------------------------
module mannix_rr_pick #(
  parameter int NUM_CLIENTS = mannix_mem_pkg::NUM_CLIENTS
) (
  input  logic [NUM_CLIENTS-1:0] req,
  input  logic [2:0]             ptr,
  output logic [2:0]             winner,
  output logic                   valid
);
  import mannix_mem_pkg::*;

  // Rotate so that bit 0 of rot is the client at ptr.
  logic [2*NUM_CLIENTS-1:0] dbl;
  logic [NUM_CLIENTS-1:0]   rot;
  int                       sum;

  assign dbl = {req, req} >> ptr;
  assign rot = dbl[NUM_CLIENTS-1:0];

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    sum    = 0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (!valid && rot[i]) begin
        valid = 1'b1;
        sum   = int'(ptr) + i;
        if (sum >= NUM_CLIENTS) begin
          sum = sum - NUM_CLIENTS;
        end
        winner = sum[2:0];
      end
    end
  end

endmodule

// File: rtl/mannix_mem_arbiter.sv
// ---------------------------------------------------------------------------
// mannix_mem_arbiter
// Arbitrates NUM_CLIENTS burst read requesters onto one SRAM read port.
// Round-robin with an optional fixed-priority override; one burst at a time.
//   clk   : single rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : mannix_mem_arbiter_if.master (client requests, grants, SRAM port)
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no burst; arbitrate whenever any req is high
// ST_BURST | issue mem_rd for the latched client, one beat per mem_ready
// ST_DONE  | one-cycle done pulse for the latched client, req ignored
// ---------------------------------------------------------------------------
module mannix_mem_arbiter #(
  parameter int NUM_CLIENTS = mannix_mem_pkg::NUM_CLIENTS,
  parameter int ADDR_W      = mannix_mem_pkg::ADDR_W,
  parameter int LEN_W       = mannix_mem_pkg::LEN_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mannix_mem_arbiter_if.master bus
);
  import mannix_mem_pkg::*;

  state_e                 state_q, state_d;
  logic [2:0]             ptr_q, ptr_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [LEN_W-1:0]       cnt_q, cnt_d;
  logic [NUM_CLIENTS-1:0] gnt_q, gnt_d;
  logic [NUM_CLIENTS-1:0] done_q, done_d;
  logic                   mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
  logic                   mem_last_q, mem_last_d;
  logic [2:0]             mem_id_q, mem_id_d;
  logic                   busy_q, busy_d;

  logic [2:0] rr_winner;
  logic       rr_valid;
  logic [7:0] req_pad;
  logic       prio_hit;
  logic [2:0] winner;

  mannix_rr_pick #(
    .NUM_CLIENTS (NUM_CLIENTS)
  ) u_rr_pick (
    .req    (bus.req),
    .ptr    (ptr_q),
    .winner (rr_winner),
    .valid  (rr_valid)
  );

  // Padding lets prio_id index 0..7 safely; out-of-range ids are rejected
  // explicitly by the compare so they fall back to round-robin.
  assign req_pad  = 8'(bus.req);
  assign prio_hit = bus.prio_en && (int'(bus.prio_id) < NUM_CLIENTS) &&
                    req_pad[bus.prio_id];
  assign winner   = prio_hit ? bus.prio_id : rr_winner;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    done_d     = '0;
    mem_rd_d   = mem_rd_q;
    mem_addr_d = mem_addr_q;
    mem_last_d = mem_last_q;
    mem_id_d   = mem_id_q;

    case (state_q)
      ST_IDLE: begin
        if (rr_valid) begin
          state_d    = ST_BURST;
          mem_id_d   = winner;
          len_d      = bus.req_len[winner];
          cnt_d      = '0;
          mem_addr_d = bus.req_addr[winner];
          gnt_d      = NUM_CLIENTS'(1) << winner;
          mem_rd_d   = 1'b1;
          mem_last_d = (bus.req_len[winner] == '0);
          // Pointer moves past the winner even on a priority grant.
          ptr_d      = (int'(winner) == NUM_CLIENTS - 1) ? 3'd0 : winner + 3'd1;
        end
      end

      ST_BURST: begin
        if (bus.mem_ready) begin
          if (cnt_q == len_q) begin
            state_d    = ST_DONE;
            gnt_d      = '0;
            mem_rd_d   = 1'b0;
            mem_last_d = 1'b0;
            done_d     = NUM_CLIENTS'(1) << mem_id_q;
          end else begin
            cnt_d      = cnt_q + LEN_W'(1);
            // Address wraps modulo 2^ADDR_W by design.
            mem_addr_d = mem_addr_q + ADDR_W'(1);
            mem_last_d = ((cnt_q + LEN_W'(1)) == len_q);
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d    = ST_IDLE;
        gnt_d      = '0;
        mem_rd_d   = 1'b0;
        mem_last_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_last_q <= 1'b0;
      mem_id_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      mem_last_q <= mem_last_d;
      mem_id_q   <= mem_id_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.done     = done_q;
  assign bus.mem_rd   = mem_rd_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_last = mem_last_q;
  assign bus.mem_id   = mem_id_q;
  assign bus.busy     = busy_q;

endmodule

// File: doc/mannix_mem_arbiter.md
MANNIX_MEM_ARBITER -- requirements
Module: mannix_mem_arbiter

Interface
REQ-001 Parameter NUM_CLIENTS, default 6: number of read requesters.
REQ-002 Parameter ADDR_W, default 19: SRAM word address width.
REQ-003 Parameter LEN_W, default 4: burst-length field width.
REQ-004 clk  in  1  Single clock; all logic SHALL be on its rising edge.
REQ-005 rst_n  in  1  Reset, synchronous, active-low.
REQ-006 req  in  NUM_CLIENTS  Per-client request; held high until that client's done.
REQ-007 req_addr  in  NUM_CLIENTS x ADDR_W  Per-client burst base address.
REQ-008 req_len  in  NUM_CLIENTS x LEN_W  Per-client burst length minus one (0 means 1 word, 15 means 16 words).
REQ-009 prio_en  in  1  Enables the fixed-priority override.
REQ-010 prio_id  in  3  Client index that wins arbitration when prio_en=1.
REQ-011 mem_ready  in  1  SRAM accepts the current read this cycle.
REQ-012 gnt  out  NUM_CLIENTS  One-hot; owner of the SRAM port.
REQ-013 mem_rd  out  1  Read strobe to the SRAM.
REQ-014 mem_addr  out  ADDR_W  Read address.
REQ-015 mem_last  out  1  Marks the final word of a burst.
REQ-016 mem_id  out  3  Index of the granted client.
REQ-017 done  out  NUM_CLIENTS  One-cycle pulse at burst completion, per client.
REQ-018 busy  out  1  High in every state except IDLE.

Function
REQ-019 FSM states: IDLE, BURST, DONE.
REQ-020 IDLE with any req bit high SHALL select a winner, latch its addr, len and id, and enter BURST on the next edge.
  - First mem_rd appears one cycle after req is seen.
REQ-021 Winner selection:
  - If prio_en=1 and prio_id<NUM_CLIENTS and req[prio_id]=1, the winner is prio_id.
  - Otherwise the winner is the first requesting client at or after the round-robin pointer, wrapping.
REQ-022 On every grant the pointer SHALL become (winner+1) mod NUM_CLIENTS, including priority grants.
REQ-023 prio_id>=NUM_CLIENTS SHALL be ignored, and round-robin applies.
REQ-024 BURST outputs:
  - gnt = one-hot of the latched id; mem_rd=1; mem_id = latched id.
  - mem_addr = base + beat count, modulo 2^ADDR_W (wraps with no error).
REQ-025 The beat count SHALL advance only in cycles with mem_rd=1 and mem_ready=1; when mem_ready=0, all outputs hold.
REQ-026 mem_last=1 SHALL accompany the beat where count equals latched len; on acceptance of that beat the FSM enters DONE.
REQ-027 DONE SHALL, for exactly one cycle:
  - assert done for the latched id;
  - drive gnt=0, mem_rd=0, busy=1;
  - ignore req;
  then return to IDLE.
REQ-028 A requester SHALL drop req in the cycle after it samples done; a req still high in IDLE is a new request.
REQ-029 Changes to req, req_addr or req_len after the grant SHALL NOT affect the burst in progress.
REQ-030 Back-to-back: with several requesters pending, grants SHALL be separated by exactly one DONE and one IDLE cycle.
REQ-031 Outside BURST, mem_rd, mem_last and gnt SHALL be 0 and mem_addr SHALL hold its last value.

Reset
REQ-032 With rst_n=0 at an edge, the block SHALL next show:
  - state IDLE, pointer 0;
  - gnt, done, mem_rd, mem_last, busy = 0; mem_addr = 0; mem_id = 0.
REQ-033 Reset mid-burst SHALL abandon the burst with no done pulse; the next edge with rst_n=1 arbitrates afresh.

Structure
REQ-034 Package mannix_mem_pkg SHALL hold:
  - NUM_CLIENTS, ADDR_W, LEN_W;
  - the client index enum: FCC_PIC=0, FCC_WGT=1, FCC_BIAS=2, CNN_PIC=3, CNN_WGT=4, POOL=5;
  - the FSM state enum.
REQ-035 Rotating-priority selection SHALL be a combinational sub-module, mannix_rr_pick, with inputs req and pointer and outputs winner index and valid.

Verification
REQ-036 Single request: req[FCC_WGT], addr 0x00100, len 3, mem_ready=1.
  - mem_rd for 4 cycles, addresses 0x00100 through 0x00103; mem_last on 0x00103.
  - done[1] one cycle later.
REQ-037 Round-robin: all six requesting, prio_en=0, pointer 0 → grant order 0,1,2,3,4,5,0.
REQ-038 Priority: all requesting, prio_en=1, prio_id=4 → client 4 wins repeatedly; prio_id=7 → pure round-robin.
REQ-039 Stall and wrap: addr 0x7FFFE, len 3, mem_ready low on the 2nd beat for 3 cycles.
  - Addresses 0x7FFFE, 0x7FFFF (held 3 cycles), 0x00000, 0x00001; 4 accepted beats.
REQ-040 Reset on the 2nd beat of a len-7 burst → outputs 0 on the next cycle, no done pulse, new grant after release.
